// File: rtl/stmm_result_packer_if.sv
// SDRAM write port between the StMM result packer and the memory side.
// The packer drives one beat at a time; the slave acknowledges with wr_ack.
interface stmm_result_packer_if #(
  parameter int ADDR_W  = 32,
  parameter int SDRAM_W = 128
);
  logic                   wr_req;
  logic [ADDR_W-1:0]      wr_addr;
  logic [SDRAM_W-1:0]     wr_data;
  logic [SDRAM_W/8-1:0]   wr_be;
  logic                   wr_ack;

  modport master (
    output wr_req, wr_addr, wr_data, wr_be,
    input  wr_ack
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, wr_be,
    output wr_ack
  );
endinterface

// File: rtl/stmm_result_packer.sv
// Captures one StMM output vector and writes it to SDRAM as SDRAM_W-bit beats.
// Define STMM_PACK_DBLBUF_EN to add a shadow buffer for back-to-back vectors.
module stmm_result_packer #(
  parameter int N       = 176,
  parameter int Q       = 8,
  parameter int SDRAM_W = 128,
  parameter int ADDR_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic                  y_valid,
  input  logic [N*Q-1:0]        y_data,
  stmm_result_packer_if.master  wr,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);
  localparam int VW     = N * Q;
  localparam int NBEATS = (VW + SDRAM_W - 1) / SDRAM_W;
  localparam int BPB    = SDRAM_W / 8;
  localparam int STRIDE = NBEATS * BPB;
  localparam int PADW   = NBEATS * SDRAM_W;
  localparam int LASTB  = (VW - (NBEATS - 1) * SDRAM_W + 7) / 8;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_SEND
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PADW-1:0]   cap_q, cap_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
`ifdef STMM_PACK_DBLBUF_EN
  logic [VW-1:0]     shd_q, shd_d;
  logic              pend_q, pend_d;
`endif

  logic send, last, fire;

  function automatic logic [PADW-1:0] pad(input logic [VW-1:0] v);
    return PADW'(v);
  endfunction

  assign send = (state_q == S_SEND);
  assign last = (beat_q == BW'(NBEATS - 1));
  assign fire = send && wr.wr_ack;

  always_comb begin
    wr.wr_req  = send;
    wr.wr_addr = '0;
    wr.wr_data = '0;
    wr.wr_be   = '0;
    if (send) begin
      wr.wr_addr = addr_q + ADDR_W'(beat_q) * ADDR_W'(BPB);
      wr.wr_data = cap_q[32'(beat_q) * SDRAM_W +: SDRAM_W];
      for (int i = 0; i < BPB; i++) begin
        wr.wr_be[i] = !last || (i < LASTB);
      end
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cap_d   = cap_q;
    beat_d  = beat_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
`ifdef STMM_PACK_DBLBUF_EN
    shd_d   = shd_q;
    pend_d  = pend_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          state_d = S_ARMED;
        end
        // start clears overflow, but a vector lost in the same cycle still counts
        ovf_d = start ? y_valid : (ovf_q | y_valid);
      end
      S_ARMED: begin
        if (start) addr_d = base_addr;
        if (y_valid) begin
          cap_d   = pad(y_data);
          beat_d  = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (fire && last) begin
          done_d  = 1'b1;
          addr_d  = addr_q + ADDR_W'(STRIDE);
          beat_d  = '0;
          state_d = S_IDLE;
`ifdef STMM_PACK_DBLBUF_EN
          if (pend_q) begin
            cap_d   = pad(shd_q);
            state_d = S_SEND;
            pend_d  = y_valid;
            if (y_valid) shd_d = y_data;
          end else if (y_valid) begin
            cap_d   = pad(y_data);
            state_d = S_SEND;
          end
`endif
        end else if (fire) begin
          beat_d = beat_q + BW'(1);
        end
`ifdef STMM_PACK_DBLBUF_EN
        if (y_valid && !(fire && last)) begin
          if (pend_q) begin
            ovf_d = 1'b1;
          end else begin
            shd_d  = y_data;
            pend_d = 1'b1;
          end
        end
`else
        if (y_valid) ovf_d = 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cap_q   <= '0;
      beat_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef STMM_PACK_DBLBUF_EN
      shd_q   <= '0;
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cap_q   <= cap_d;
      beat_q  <= beat_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
`ifdef STMM_PACK_DBLBUF_EN
      shd_q   <= shd_d;
      pend_q  <= pend_d;
`endif
    end
  end
endmodule
